// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder: FSM states, SPI mode
// encodings and the bit counter width helper.
package spi_slave_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int CPOL_IDLE_LOW        = 0;
    localparam int CPOL_IDLE_HIGH       = 1;
    localparam int CPHA_SAMPLE_LEADING  = 0;
    localparam int CPHA_SAMPLE_TRAILING = 1;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, followed by a delay flop
// so rising and falling transitions of the synchronized level can be flagged.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            dly_q  <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave_peripheral.sv
// SPI responder oversampled by the system clock: shifts a word in from MOSI
// and out on MISO per select, fed by a one-deep valid/ready transmit buffer.
module spi_slave_peripheral
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                CPOL   = 0,
    parameter int                CPHA   = 0,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_SCLK,
    input  logic              spi_MOSI,
    input  logic              spi_SS_n,
    output logic              spi_MISO,
    output logic              spi_MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W      = clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic            CPOL_LEVEL = (CPOL == CPOL_IDLE_HIGH);

    logic sclkSync, sclkRise, sclkFall;
    logic ssSync, ssRise, ssFall;
    logic mosiMeta_q, mosiSync_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic              wordStart_q, wordStart_d;
    logic [DATA_W-1:0] txShift_q, txShift_d;
    logic [DATA_W-2:0] rxShift_q, rxShift_d;
    logic [DATA_W-1:0] rxData_q, rxData_d;
    logic              rxValid_q, rxValid_d;
    logic [DATA_W-1:0] txBuf_q, txBuf_d;
    logic              txFull_q, txFull_d;
    logic              underrun_q, underrun_d;

    logic              sclkEnable, leadingEdge, trailingEdge;
    logic              sampleEdge, shiftEdge, doLoad;
    logic [DATA_W-1:0] rxWord;

    spi_sync_edge #(.RESET_VAL(CPOL_LEVEL)) u_sclkSync (
        .clk_i   (clk_clk),
        .reset_i (reset_reset),
        .async_i (spi_SCLK),
        .sync_o  (sclkSync),
        .rise_o  (sclkRise),
        .fall_o  (sclkFall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ssSync (
        .clk_i   (clk_clk),
        .reset_i (reset_reset),
        .async_i (spi_SS_n),
        .sync_o  (ssSync),
        .rise_o  (ssRise),
        .fall_o  (ssFall)
    );

    // MOSI only needs the level; it is stable across the SCLK edge it is sampled on.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
        end else begin
            mosiMeta_q <= spi_MOSI;
            mosiSync_q <= mosiMeta_q;
        end
    end

    assign sclkEnable   = (state_q == ACTIVE) && !ssSync;
    assign leadingEdge  = sclkEnable && (sclkRise | sclkFall) && (sclkSync != CPOL_LEVEL);
    assign trailingEdge = sclkEnable && (sclkRise | sclkFall) && (sclkSync == CPOL_LEVEL);
    assign sampleEdge   = (CPHA == CPHA_SAMPLE_TRAILING) ? trailingEdge : leadingEdge;
    assign shiftEdge    = (CPHA == CPHA_SAMPLE_TRAILING) ? leadingEdge : trailingEdge;
    assign rxWord       = {rxShift_q, mosiSync_q};

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        wordStart_d = wordStart_q;
        txShift_d   = txShift_q;
        rxShift_d   = rxShift_q;
        rxData_d    = rxData_q;
        rxValid_d   = 1'b0;
        txBuf_d     = txBuf_q;
        txFull_d    = txFull_q;
        underrun_d  = 1'b0;
        doLoad      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ssFall) begin
                    state_d     = ACTIVE;
                    bitCnt_d    = '0;
                    wordStart_d = 1'b1;
                    // Sampling on the leading edge needs the MSB on MISO before any SCLK edge.
                    if (CPHA == CPHA_SAMPLE_LEADING) begin
                        doLoad      = 1'b1;
                        wordStart_d = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                if (ssRise) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end else begin
                    if (shiftEdge) begin
                        if (wordStart_q) begin
                            doLoad      = 1'b1;
                            wordStart_d = 1'b0;
                        end else begin
                            txShift_d = txShift_q << 1;
                        end
                    end
                    if (sampleEdge) begin
                        rxShift_d = rxWord[DATA_W-2:0];
                        if (bitCnt_q == LAST_BIT) begin
                            rxData_d    = rxWord;
                            rxValid_d   = 1'b1;
                            bitCnt_d    = '0;
                            wordStart_d = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load from an empty buffer takes FILL even if a word is being written this cycle.
        if (doLoad) begin
            if (txFull_q) begin
                txShift_d = txBuf_q;
                txFull_d  = 1'b0;
            end else begin
                txShift_d  = FILL;
                underrun_d = 1'b1;
            end
        end
        if (tx_valid && !txFull_q) begin
            txBuf_d  = tx_data;
            txFull_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            wordStart_q <= 1'b0;
            txShift_q   <= '0;
            rxShift_q   <= '0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            txBuf_q     <= '0;
            txFull_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            wordStart_q <= wordStart_d;
            txShift_q   <= txShift_d;
            rxShift_q   <= rxShift_d;
            rxData_q    <= rxData_d;
            rxValid_q   <= rxValid_d;
            txBuf_q     <= txBuf_d;
            txFull_q    <= txFull_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_MISO    = (state_q == ACTIVE) && txShift_q[DATA_W-1];
    assign spi_MISO_oe = (state_q == ACTIVE);
    assign busy        = (state_q == ACTIVE);
    assign tx_ready    = !txFull_q;
    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_peripheral.sv
// Directed bench: one responder in mode 0 and one in mode 3 share SCLK/MOSI,
// each with its own select, driven by a bit-banged master at clk/8.
module tb_spi_slave_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, mosi, ssA, ssB;

    logic       misoA, misoOeA, txValidA, txReadyA, rxValidA, underrunA, busyA;
    logic [7:0] txDataA, rxDataA;
    logic       misoB, misoOeB, txValidB, txReadyB, rxValidB, underrunB, busyB;
    logic [7:0] txDataB, rxDataB;

    int         checks = 0;
    int         fails = 0;
    int         rxCountA = 0, rxCountB = 0, undCountA = 0, undCountB = 0;
    logic [7:0] lastRxA = '0, lastRxB = '0;
    logic [7:0] rxLogB[$];

    int         rxBefore, undBefore;
    logic [7:0] got, got0, got1, got2;

    always #5 clk = ~clk;

    spi_slave_peripheral #(.DATA_W(8), .CPOL(0), .CPHA(0), .FILL(8'h00)) dutA (
        .clk_clk(clk), .reset_reset(rst),
        .spi_SCLK(sclk), .spi_MOSI(mosi), .spi_SS_n(ssA),
        .spi_MISO(misoA), .spi_MISO_oe(misoOeA),
        .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReadyA),
        .rx_data(rxDataA), .rx_valid(rxValidA), .tx_underrun(underrunA), .busy(busyA)
    );

    spi_slave_peripheral #(.DATA_W(8), .CPOL(1), .CPHA(1), .FILL(8'h00)) dutB (
        .clk_clk(clk), .reset_reset(rst),
        .spi_SCLK(sclk), .spi_MOSI(mosi), .spi_SS_n(ssB),
        .spi_MISO(misoB), .spi_MISO_oe(misoOeB),
        .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReadyB),
        .rx_data(rxDataB), .rx_valid(rxValidB), .tx_underrun(underrunB), .busy(busyB)
    );

    // Strobe monitor sits just after the active edge, away from the checks at negedge.
    always @(posedge clk) begin
        #1;
        if (rxValidA === 1'b1) begin
            rxCountA++;
            lastRxA = rxDataA;
        end
        if (rxValidB === 1'b1) begin
            rxCountB++;
            lastRxB = rxDataB;
            rxLogB.push_back(rxDataB);
        end
        if (underrunA === 1'b1) undCountA++;
        if (underrunB === 1'b1) undCountB++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic halfBit();
        repeat (4) @(negedge clk);
    endtask

    task automatic writeTx(input bit useB, input logic [7:0] word);
        int waitCnt;
        waitCnt = 0;
        while (!(useB ? txReadyB : txReadyA) && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 300) checkOutput("txReadyTimeout", 32'd0, 32'd1);
        if (useB) begin txDataB = word; txValidB = 1'b1; end
        else      begin txDataA = word; txValidA = 1'b1; end
        @(negedge clk);
        txValidA = 1'b0;
        txValidB = 1'b0;
    endtask

    task automatic spiSelect(input bit useB, input bit cpol);
        sclk = cpol;
        repeat (4) @(negedge clk);
        if (useB) ssB = 1'b0; else ssA = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spiDeselect(input bit useB);
        halfBit();
        if (useB) ssB = 1'b1; else ssA = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Master side of one word, MSB first; MISO is captured on the master's sample edge.
    task automatic applyStimulus(input bit useB, input bit cpol, input bit cpha,
                                 input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
        rxByte = '0;
        for (int i = 0; i < nBits; i++) begin
            if (!cpha) begin
                mosi = txByte[7-i];
                halfBit();
                sclk = ~cpol;
                rxByte = {rxByte[6:0], (useB ? misoB : misoA)};
                halfBit();
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = txByte[7-i];
                halfBit();
                sclk = cpol;
                rxByte = {rxByte[6:0], (useB ? misoB : misoA)};
                halfBit();
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        rst = 1'b1;
        sclk = 1'b0; mosi = 1'b0; ssA = 1'b1; ssB = 1'b1;
        txValidA = 1'b0; txValidB = 1'b0; txDataA = '0; txDataB = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstMisoA", misoA, 0);
        checkOutput("rstOeA", misoOeA, 0);
        checkOutput("rstRxDataA", rxDataA, 0);
        checkOutput("rstRxValidA", rxValidA, 0);
        checkOutput("rstReadyA", txReadyA, 1);
        checkOutput("rstUnderrunA", underrunA, 0);
        checkOutput("rstBusyA", busyA, 0);
        checkOutput("rstReadyB", txReadyB, 1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] mode 0 transfer, preloaded 0xA5");
        writeTx(1'b0, 8'hA5);
        checkOutput("preloadReadyA", txReadyA, 0);
        rxBefore = rxCountA;
        spiSelect(1'b0, 1'b0);
        checkOutput("loadReadyA", txReadyA, 1);
        checkOutput("selOeA", misoOeA, 1);
        checkOutput("selBusyA", busyA, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h3C, 8, got);
        spiDeselect(1'b0);
        checkOutput("m0MasterRx", got, 8'hA5);
        checkOutput("m0RxCount", rxCountA - rxBefore, 1);
        checkOutput("m0RxData", lastRxA, 8'h3C);
        checkOutput("m0IdleOe", misoOeA, 0);

        $display("[TB] mode 3 three-word burst");
        writeTx(1'b1, 8'h11);
        rxLogB.delete();
        undBefore = undCountB;
        spiSelect(1'b1, 1'b1);
        fork
            begin
                writeTx(1'b1, 8'h22);
                writeTx(1'b1, 8'h33);
            end
            begin
                applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 8, got0);
                applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 8, got1);
                applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8, got2);
            end
        join
        spiDeselect(1'b1);
        checkOutput("m3MasterRx0", got0, 8'h11);
        checkOutput("m3MasterRx1", got1, 8'h22);
        checkOutput("m3MasterRx2", got2, 8'h33);
        checkOutput("m3RxCount", rxLogB.size(), 3);
        if (rxLogB.size() >= 3) begin
            checkOutput("m3RxWord0", rxLogB[0], 8'h01);
            checkOutput("m3RxWord1", rxLogB[1], 8'h80);
            checkOutput("m3RxWord2", rxLogB[2], 8'hFF);
        end
        checkOutput("m3NoUnderrun", undCountB - undBefore, 0);

        $display("[TB] mode 3 empty buffer");
        undBefore = undCountB;
        rxBefore = rxCountB;
        spiSelect(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 8, got);
        spiDeselect(1'b1);
        checkOutput("emptyMasterRx", got, 8'h00);
        checkOutput("emptyUnderrun", undCountB - undBefore, 1);
        checkOutput("emptyRxCount", rxCountB - rxBefore, 1);
        checkOutput("emptyRxData", lastRxB, 8'h55);

        $display("[TB] mode 0 abort after five bits");
        rxBefore = rxCountA;
        spiSelect(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 5, got);
        checkOutput("abortBusyBefore", busyA, 1);
        halfBit();
        ssA = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abortBusy", busyA, 0);
        checkOutput("abortOe", misoOeA, 0);
        checkOutput("abortNoRx", rxCountA - rxBefore, 0);
        repeat (4) @(negedge clk);
        spiSelect(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h96, 8, got);
        spiDeselect(1'b0);
        checkOutput("postAbortRxCount", rxCountA - rxBefore, 1);
        checkOutput("postAbortRxData", lastRxA, 8'h96);

        $display("[TB] reset after three bits");
        writeTx(1'b0, 8'h5A);
        rxBefore = rxCountA;
        spiSelect(1'b0, 1'b0);
        writeTx(1'b0, 8'h77);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hF0, 3, got);
        rst = 1'b1;
        ssA = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstMiso", misoA, 0);
        checkOutput("midRstOe", misoOeA, 0);
        checkOutput("midRstRxData", rxDataA, 0);
        checkOutput("midRstRxValid", rxValidA, 0);
        checkOutput("midRstReady", txReadyA, 1);
        checkOutput("midRstUnderrun", underrunA, 0);
        checkOutput("midRstBusy", busyA, 0);
        repeat (4) @(negedge clk);
        writeTx(1'b0, 8'hC3);
        spiSelect(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h69, 8, got);
        spiDeselect(1'b0);
        checkOutput("postRstMasterRx", got, 8'hC3);
        checkOutput("postRstRxCount", rxCountA - rxBefore, 1);
        checkOutput("postRstRxData", lastRxA, 8'h69);

        $display("[TB] write in the same cycle as the select load");
        undBefore = undCountA;
        rxBefore = rxCountA;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        ssA = 1'b0;
        @(negedge clk);
        @(negedge clk);
        txDataA = 8'hE1;
        txValidA = 1'b1;
        @(negedge clk);
        txValidA = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("simReadyHeld", txReadyA, 0);
        checkOutput("simUnderrun", undCountA - undBefore, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h12, 8, got);
        checkOutput("simFirstWordFill", got, 8'h00);
        halfBit();
        checkOutput("simReadyAfterLoad", txReadyA, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h34, 8, got);
        spiDeselect(1'b0);
        checkOutput("simSecondWord", got, 8'hE1);
        checkOutput("simRxCount", rxCountA - rxBefore, 2);
        checkOutput("simRxData", lastRxA, 8'h34);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
